// File: rtl/lut_func_unit.sv
// lut_func_unit
//   Programmable N-input Boolean function unit built around a 2**N_IN-entry
//   truth-table register. It provides two services:
//     - registered evaluation F = table[in_vec];
//     - a sweep that streams every minterm value over a valid/ready handshake
//       and counts the accepted beats whose value is 1.
//
// Ports
//   clk          in   1          rising-edge clock
//   reset_n      in   1          synchronous active-low reset
//   tbl_we       in   1          load truth table from tbl_data (IDLE only)
//   tbl_data     in   TABLE_W    new truth table, bit i = F for input value i
//   in_vec       in   N_IN       live input vector, MSB is input A
//   F            out  1          registered table[in_vec]
//   sweep_start  in   1          request a minterm sweep
//   sweep_busy   out  1          high while sweeping
//   sw_valid     out  1          sweep beat valid
//   sw_ready     in   1          downstream accepts the beat
//   sw_index     out  N_IN       minterm index of the current beat
//   sw_f         out  1          table[sw_index]
//   sw_done      out  1          one-cycle pulse after the last beat transfers
//   ones_count   out  N_IN+1     accepted beats with sw_f = 1
module lut_func_unit #(
  parameter int N_IN = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tbl_we,
  input  logic [(2**N_IN)-1:0]    tbl_data,
  input  logic [N_IN-1:0]         in_vec,
  output logic                    F,
  input  logic                    sweep_start,
  output logic                    sweep_busy,
  output logic                    sw_valid,
  input  logic                    sw_ready,
  output logic [N_IN-1:0]         sw_index,
  output logic                    sw_f,
  output logic                    sw_done,
  output logic [N_IN:0]           ones_count
);

  localparam int TABLE_W = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_INDEX = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] INDEX_ONE  = {{(N_IN-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t              stateQ;
  logic [TABLE_W-1:0]  tableQ;
  logic [N_IN-1:0]     nextIndex;

  assign nextIndex = sw_index + INDEX_ONE;

  // Truth table, evaluation output and sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stateQ     <= IDLE;
      tableQ     <= {TABLE_W{1'b0}};
      F          <= 1'b0;
      sweep_busy <= 1'b0;
      sw_valid   <= 1'b0;
      sw_index   <= {N_IN{1'b0}};
      sw_f       <= 1'b0;
      sw_done    <= 1'b0;
      ones_count <= {(N_IN+1){1'b0}};
    end else begin
      // Evaluation always uses the table as it stood before this edge.
      F       <= tableQ[in_vec];
      sw_done <= 1'b0;

      case (stateQ)
        IDLE: begin
          if (tbl_we) begin
            // A write takes priority over a coincident sweep request.
            tableQ <= tbl_data;
          end else if (sweep_start) begin
            stateQ     <= SWEEP;
            sweep_busy <= 1'b1;
            sw_valid   <= 1'b1;
            sw_index   <= {N_IN{1'b0}};
            sw_f       <= tableQ[0];
            ones_count <= {(N_IN+1){1'b0}};
          end else begin
            stateQ <= IDLE;
          end
        end

        SWEEP: begin
          // The table is frozen here; tbl_we and sweep_start are ignored.
          if (sw_valid && sw_ready) begin
            ones_count <= ones_count + {{N_IN{1'b0}}, sw_f};
            if (sw_index != LAST_INDEX) begin
              sw_index <= nextIndex;
              sw_f     <= tableQ[nextIndex];
            end else begin
              stateQ     <= IDLE;
              sweep_busy <= 1'b0;
              sw_valid   <= 1'b0;
              sw_index   <= {N_IN{1'b0}};
              sw_f       <= 1'b0;
              sw_done    <= 1'b1;
            end
          end else begin
            stateQ <= SWEEP;
          end
        end

        default: begin
          stateQ     <= IDLE;
          sweep_busy <= 1'b0;
          sw_valid   <= 1'b0;
          sw_index   <= {N_IN{1'b0}};
          sw_f       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_func_unit.sv
// tb_lut_func_unit
//   Directed bench for lut_func_unit with N_IN = 4. Inputs change 1 time unit
//   after each rising edge; outputs are sampled at the same point, before the
//   new inputs are applied.
module tb_lut_func_unit;

  localparam int N_IN = 4;

  logic        clk;
  logic        reset_n;
  logic        tbl_we;
  logic [15:0] tbl_data;
  logic [3:0]  in_vec;
  logic        F;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sw_valid;
  logic        sw_ready;
  logic [3:0]  sw_index;
  logic        sw_f;
  logic        sw_done;
  logic [4:0]  ones_count;

  int totalCount;
  int badCount;
  int doneSeen;

  lut_func_unit #(.N_IN(N_IN)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tbl_we      (tbl_we),
    .tbl_data    (tbl_data),
    .in_vec      (in_vec),
    .F           (F),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sw_valid    (sw_valid),
    .sw_ready    (sw_ready),
    .sw_index    (sw_index),
    .sw_f        (sw_f),
    .sw_done     (sw_done),
    .ones_count  (ones_count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    if (obs !== exp) begin
      badCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    totalCount  = 0;
    badCount    = 0;
    reset_n     = 1'b0;
    tbl_we      = 1'b0;
    tbl_data    = 16'h0000;
    in_vec      = 4'h0;
    sweep_start = 1'b0;
    sw_ready    = 1'b0;

    // Reset for two edges.
    step();
    step();
    checkVal("rst_F",     {31'd0, F},          32'd0);
    checkVal("rst_busy",  {31'd0, sweep_busy}, 32'd0);
    checkVal("rst_valid", {31'd0, sw_valid},   32'd0);
    checkVal("rst_index", {28'd0, sw_index},   32'd0);
    checkVal("rst_swf",   {31'd0, sw_f},       32'd0);
    checkVal("rst_done",  {31'd0, sw_done},    32'd0);
    checkVal("rst_ones",  {27'd0, ones_count}, 32'd0);

    // Eval latency: write at edge k, visible on F from edge k+1.
    reset_n  = 1'b1;
    tbl_we   = 1'b1;
    tbl_data = 16'h8000;
    in_vec   = 4'hF;
    step();
    tbl_we = 1'b0;
    checkVal("eval_old_table", {31'd0, F}, 32'd0);
    step();
    checkVal("eval_F_1", {31'd0, F}, 32'd1);
    in_vec = 4'hE;
    step();
    checkVal("eval_F_0", {31'd0, F}, 32'd0);

    // Odd-parity sweep with sw_ready held high.
    tbl_we   = 1'b1;
    tbl_data = 16'h6996;
    step();
    tbl_we      = 1'b0;
    sweep_start = 1'b1;
    sw_ready    = 1'b1;
    step();
    sweep_start = 1'b0;
    checkVal("par_busy",  {31'd0, sweep_busy}, 32'd1);
    checkVal("par_ones0", {27'd0, ones_count}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] idx;
      idx = i[3:0];
      checkVal("par_valid", {31'd0, sw_valid}, 32'd1);
      checkVal("par_index", {28'd0, sw_index}, i);
      checkVal("par_swf",   {31'd0, sw_f},     {31'd0, ^idx});
      checkVal("par_nodone", {31'd0, sw_done}, 32'd0);
      step();
    end
    checkVal("par_done",   {31'd0, sw_done},    32'd1);
    checkVal("par_idle",   {31'd0, sweep_busy}, 32'd0);
    checkVal("par_novalid", {31'd0, sw_valid},  32'd0);
    checkVal("par_ones",   {27'd0, ones_count}, 32'd8);
    checkVal("par_idx0",   {28'd0, sw_index},   32'd0);
    step();
    checkVal("par_done_pulse", {31'd0, sw_done}, 32'd0);
    checkVal("par_ones_hold", {27'd0, ones_count}, 32'd8);

    // Backpressure at index 0.
    tbl_we   = 1'b1;
    tbl_data = 16'h0001;
    step();
    tbl_we      = 1'b0;
    sweep_start = 1'b1;
    sw_ready    = 1'b0;
    step();
    sweep_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkVal("bp_index", {28'd0, sw_index},   32'd0);
      checkVal("bp_swf",   {31'd0, sw_f},       32'd1);
      checkVal("bp_valid", {31'd0, sw_valid},   32'd1);
      checkVal("bp_ones",  {27'd0, ones_count}, 32'd0);
      step();
    end
    sw_ready = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (sw_done) doneSeen++;
    end
    checkVal("bp_done_once", doneSeen, 32'd1);
    checkVal("bp_ones_final", {27'd0, ones_count}, 32'd1);

    // All-ones table with an ignored write mid-sweep.
    tbl_we   = 1'b1;
    tbl_data = 16'hFFFF;
    step();
    tbl_we      = 1'b0;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkVal("ff_index", {28'd0, sw_index}, i);
      checkVal("ff_swf",   {31'd0, sw_f},     32'd1);
      tbl_we   = (i >= 4 && i <= 8) ? 1'b1 : 1'b0;
      tbl_data = 16'h0000;
      // A second start inside the sweep must not restart it.
      sweep_start = (i == 6) ? 1'b1 : 1'b0;
      step();
    end
    tbl_we      = 1'b0;
    sweep_start = 1'b0;
    checkVal("ff_done", {31'd0, sw_done},    32'd1);
    checkVal("ff_ones", {27'd0, ones_count}, 32'd16);
    in_vec = 4'h3;
    step();
    step();
    checkVal("ff_table_frozen", {31'd0, F}, 32'd1);

    // Start coincident with a write: write wins, no sweep.
    tbl_we      = 1'b1;
    tbl_data    = 16'h00F0;
    sweep_start = 1'b1;
    in_vec      = 4'h0;
    step();
    tbl_we      = 1'b0;
    sweep_start = 1'b0;
    checkVal("co_busy",  {31'd0, sweep_busy}, 32'd0);
    checkVal("co_valid", {31'd0, sw_valid},   32'd0);
    step();
    checkVal("co_written", {31'd0, F}, 32'd0);
    in_vec = 4'h5;
    step();
    step();
    checkVal("co_written_hi", {31'd0, F}, 32'd1);

    // Abort by reset at index 7.
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checkVal("ab_index7", {28'd0, sw_index},   32'd7);
    checkVal("ab_ones3",  {27'd0, ones_count}, 32'd3);
    reset_n = 1'b0;
    step();
    checkVal("ab_busy",  {31'd0, sweep_busy}, 32'd0);
    checkVal("ab_valid", {31'd0, sw_valid},   32'd0);
    checkVal("ab_ones",  {27'd0, ones_count}, 32'd0);
    checkVal("ab_index", {28'd0, sw_index},   32'd0);
    reset_n  = 1'b1;
    doneSeen = 0;
    if (sw_done) doneSeen++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sw_done) doneSeen++;
    end
    checkVal("ab_no_done", doneSeen, 32'd0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
